// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and flag derivation.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    OP_NOT = 3'd0,
    OP_OR  = 3'd1,
    OP_AND = 3'd2,
    OP_NEG = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } alu_op_e;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_D = 2;
  localparam int unsigned FLG_W = 3;

  // Width-independent: caller supplies the zero test and the sign bit.
  function automatic logic [FLG_W-1:0] alu_flags(input logic       is_zero,
                                                 input logic       msb,
                                                 input logic [2:0] op,
                                                 input logic       divz);
    logic [FLG_W-1:0] f;
    f        = '0;
    f[FLG_Z] = is_zero;
    f[FLG_N] = msb;
    f[FLG_D] = (op == OP_DIV) && divz;
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with explicit occupancy count and flush.
module sync_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Gating on empty gives a zero head after reset without resetting storage.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Registered output stage for the ALU: derives status flags at accept time and
// queues {flags, op, res} so consumer back-pressure never reaches the ALU path.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_res,
  input  logic [2:0]             in_op,
  input  logic                   in_divz,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_res,
  output logic [2:0]             out_op,
  output logic [2:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   divz_sticky
);

  localparam int unsigned DW = W + 6;

  logic [FLG_W-1:0] in_flags;
  logic [DW-1:0]    wr_word;
  logic [DW-1:0]    rd_word;
  logic             full;
  logic             empty;
  logic             push;

  always_comb begin
    in_flags = '0;
    in_flags = alu_flags(in_res == '0, in_res[W-1], in_op, in_divz);
  end

  assign wr_word   = {in_flags, in_op, in_res};
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;

  assign out_res   = rd_word[W-1:0];
  assign out_op    = rd_word[W+2:W];
  assign out_flags = rd_word[W+5:W+3];

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (in_valid),
    .wr_data (wr_word),
    .rd_en   (out_ready),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Input presented during flush is discarded, so it cannot set the sticky bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divz_sticky <= 1'b0;
    end else if (flush) begin
      divz_sticky <= 1'b0;
    end else if (push && in_flags[FLG_D]) begin
      divz_sticky <= 1'b1;
    end
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage directly downstream of the 32-bit combinational ALU. Each cycle it can accept one ALU result together with its 3-bit opcode and a divide-by-zero indication. It derives status flags and buffers result, opcode and flags in a small FIFO. Downstream consumers drain the FIFO over a valid/ready handshake, so the combinational ALU path is decoupled from consumer back-pressure.

## Interface
Parameters:
- `W`, 32, result width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_res`  in  W  ALU result.
- `in_op`  in  3  ALU select that produced `in_res`.
- `in_divz`  in  1  divisor was zero; meaningful only when `in_op`=3'b111.
- `flush`  in  1  synchronous clear of contents and sticky status.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes head entry.
- `out_res`  out  W  head result.
- `out_op`  out  3  head opcode.
- `out_flags`  out  3  head flags: [0] Z, [1] N, [2] D.
- `count`  out  clog2(DEPTH)+1  current occupancy.
- `divz_sticky`  out  1  set once any divide-by-zero entry is accepted.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Flags are computed at push time from the inputs:
  - Z = (`in_res` == 0)
  - N = `in_res[W-1]`
  - D = (`in_op` == 3'b111) && `in_divz`
- Flags are stored with the entry and are never recomputed.
- `in_ready` = !full. It does not depend on `out_ready`, so no combinational path runs from output to input.
- `out_valid` = (count != 0). `out_res`, `out_op` and `out_flags` show the head entry (first-word-fall-through from registered storage). These outputs are don't-care when `out_valid` is low.
- Storage is a circular buffer:
  - Read and write pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - `count` is maintained explicitly: +1 on push only, −1 on pop only, unchanged on push+pop.
- `divz_sticky` sets on any push with D=1 and stays set until `flush` or `rst`.
- `flush` has priority over push and pop in the same cycle:
  - Pointers and count go to 0 and `divz_sticky` clears.
  - An input presented in the flush cycle is discarded.
- Boundary rules:
  - Full: `in_ready`=0. A simultaneous pop frees a slot, but push stays blocked until the next cycle.
  - Empty: a push is visible at the output next cycle. There is no same-cycle bypass.
  - Full or non-empty with push and pop together: both happen and count is unchanged.
  - Reset mid-transfer: all state clears immediately and in-flight entries are lost.
- `in_op` is stored as given. Reserved or unknown values are not checked.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1, `count`=0, `divz_sticky`=0.
  - `out_res`=0, `out_op`=0, `out_flags`=0 (storage array need not be reset; output mux reads a reset head register or gates to 0 when empty).
- Latency from push to `out_valid` is 1 cycle.
- Throughput is 1 entry per cycle in both directions when neither side stalls.
- Output fields stay stable while `out_valid && !out_ready`.
- All outputs are registered or decoded from registered state only.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_NOT`=0, `OP_OR`=1, `OP_AND`=2, `OP_NEG`=3, `OP_ADD`=4, `OP_SUB`=5, `OP_MUL`=6, `OP_DIV`=7.
  - Flag index constants `FLG_Z`=0, `FLG_N`=1, `FLG_D`=2.
  - `ALU_W`=32.
- Sub-module `sync_fifo`, parameterised on data width and depth, provides pointers, count, full/empty and flush. The top level holds flag generation and the sticky status, and packs `{flags, op, res}` into one FIFO word (W+6 bits).

## Test plan
- Reset and single push: `rst` pulse, then push `in_res`=0x0000_0000, `in_op`=4. After 1 cycle: `out_valid`=1, `out_flags`=3'b001, `count`=1. Pop, then `count`=0 and `out_valid`=0.
- Negative flag: push 0xFFFF_FFFE with `in_op`=5. Head shows `out_flags`=3'b010 and `out_op`=5.
- Fill and back-pressure: hold `out_ready`=0 and push 4 entries 1..4. `in_ready`=0 and `count`=4. A fifth `in_valid` is not accepted. Drain returns 1, 2, 3, 4 in order.
- Simultaneous push/pop with pointer wrap: stream 10 entries with both sides ready every cycle. Count stays at 1 after the first push and ordering is preserved across the wrap.
- Divide-by-zero: push `in_op`=7, `in_divz`=1, `in_res`=0. Flags are 3'b101 and `divz_sticky`=1. It stays 1 after the entry is popped and clears on `flush`.
- Flush and async reset: with 3 entries queued, assert `flush` together with a push and a pop. Next cycle `count`=0 and `out_valid`=0. Assert `rst` between clock edges with entries queued: outputs reach reset values without waiting for a clock edge.
